// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Fill bit used when widening the multiplicand to the accumulator width.
  function automatic logic ext_fill(input logic msb, input logic is_signed);
    return msb & is_signed;
  endfunction

endpackage

// File: rtl/mult_pp_row.sv
// One gated partial-product row: adds or subtracts (multiplicand << shamt)
// into the accumulator when the multiplier bit for this step is set.
module mult_pp_row
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [2*WIDTH-1:0] mcand_ext,
  input  logic [CNT_W-1:0]   shamt,
  input  logic               gate,
  input  logic               sub,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] pp_s;

  // Shifted partial product, then gated add/subtract (modulo 2^(2*WIDTH)).
  always_comb begin
    pp_s     = mcand_ext << shamt;
    acc_next = acc;
    if (gate) begin
      if (sub) begin
        acc_next = acc - pp_s;
      end else begin
        acc_next = acc + pp_s;
      end
    end else begin
      acc_next = acc;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per clock, with
// valid/ready handshakes and per-operation signed/unsigned mode.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               signed_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               ovld_q, ovld_d;
  logic               irdy_q, irdy_d;

  logic [2*WIDTH-1:0] mcand_ext_s;
  logic [2*WIDTH-1:0] acc_row_s;
  logic               gate_s;
  logic               last_s;
  logic               sub_s;

  assign in_ready  = irdy_q;
  assign out_valid = ovld_q;
  assign product   = prod_q;

  // Row controls derived from the current iteration index.
  always_comb begin
    mcand_ext_s = {{WIDTH{ext_fill(a_q[WIDTH-1], sgn_q)}}, a_q};
    gate_s      = |(b_q & (WIDTH'(1) << cnt_q));
    last_s      = (cnt_q == CNT_W'(WIDTH - 1));
    // The MSB of a two's-complement multiplier carries negative weight.
    sub_s       = sgn_q & last_s;
  end

  mult_pp_row #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_row (
    .mcand_ext (mcand_ext_s),
    .shamt     (cnt_q),
    .gate      (gate_s),
    .sub       (sub_s),
    .acc       (acc_q),
    .acc_next  (acc_row_s)
  );

  // Next-state and datapath update for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    ovld_d  = ovld_q;
    irdy_d  = irdy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && irdy_q) begin
          a_d     = a_in;
          b_d     = b_in;
          sgn_d   = signed_in;
          acc_d   = {(2*WIDTH){1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          irdy_d  = 1'b0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d = acc_row_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_s) begin
          prod_d  = acc_row_s;
          ovld_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          irdy_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        ovld_d  = 1'b0;
        irdy_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sgn_q   <= 1'b0;
      acc_q   <= {(2*WIDTH){1'b0}};
      prod_q  <= {(2*WIDTH){1'b0}};
      ovld_q  <= 1'b0;
      irdy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      ovld_q  <= ovld_d;
      irdy_q  <= irdy_d;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: directed WIDTH=4 vectors and corner sequences, plus a
// randomised WIDTH=8 sweep against an arithmetic reference model.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       rst4, in_valid4, in_ready4, s4, out_valid4, out_ready4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  // WIDTH=8 instance
  logic        rst8, in_valid8, in_ready8, s8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a_in(a4), .b_in(b4), .signed_in(s4), .out_valid(out_valid4),
    .out_ready(out_ready4), .product(p4)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a_in(a8), .b_in(b8), .signed_in(s8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(p8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    return p[15:0];
  endfunction

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic tick4();
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                      input logic [7:0] exp, input string nm);
    int lat;
    chk({nm, "_in_ready_idle"}, 64'(in_ready4), 64'd1);
    a4 = a; b4 = b; s4 = s; in_valid4 = 1'b1; out_ready4 = 1'b1;
    tick4();
    in_valid4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
    chk({nm, "_in_ready_busy"}, 64'(in_ready4), 64'd0);
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      tick4();
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd4);
    chk({nm, "_product"}, 64'(p4), 64'(exp));
    tick4();
    chk({nm, "_out_valid_after"}, 64'(out_valid4), 64'd0);
    chk({nm, "_in_ready_after"}, 64'(in_ready4), 64'd1);
  endtask

  logic [15:0] exp_q[$];
  int          got8;
  bit          drv_done;

  initial begin
    int seen;
    rst4 = 1'b1; rst8 = 1'b1;
    in_valid4 = 1'b0; in_valid8 = 1'b0;
    a4 = 4'd0; b4 = 4'd0; s4 = 1'b0; out_ready4 = 1'b0;
    a8 = 8'd0; b8 = 8'd0; s8 = 1'b0; out_ready8 = 1'b0;
    got8 = 0; drv_done = 1'b0;

    tbl[0]  = '{4'hF, 4'hF, 1'b0, 8'hE1};
    tbl[1]  = '{4'h8, 4'h8, 1'b1, 8'h40};
    tbl[2]  = '{4'h8, 4'h7, 1'b1, 8'hC8};
    tbl[3]  = '{4'h7, 4'hF, 1'b1, 8'hF9};
    tbl[4]  = '{4'hF, 4'h2, 1'b0, 8'h1E};
    tbl[5]  = '{4'hF, 4'h2, 1'b1, 8'hFE};
    tbl[6]  = '{4'h0, 4'h0, 1'b0, 8'h00};
    tbl[7]  = '{4'hF, 4'hF, 1'b1, 8'h01};
    tbl[8]  = '{4'h8, 4'h8, 1'b0, 8'h40};
    tbl[9]  = '{4'h8, 4'h1, 1'b1, 8'hF8};
    tbl[10] = '{4'h7, 4'h7, 1'b1, 8'h31};

    tick4(); tick4();
    rst4 = 1'b0; rst8 = 1'b0;
    chk("reset_in_ready4", 64'(in_ready4), 64'd1);
    chk("reset_out_valid4", 64'(out_valid4), 64'd0);
    chk("reset_product4", 64'(p4), 64'd0);
    chk("reset_in_ready8", 64'(in_ready8), 64'd1);
    chk("reset_out_valid8", 64'(out_valid8), 64'd0);
    chk("reset_product8", 64'(p8), 64'd0);

    for (int i = 0; i < 11; i++) begin
      run4(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Backpressure: 6*7 held for 10 cycles while in_valid pulses are ignored
    a4 = 4'd6; b4 = 4'd7; s4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
    tick4();
    in_valid4 = 1'b0;
    seen = 0;
    while (!out_valid4 && seen < 20) begin tick4(); seen++; end
    chk("bp_out_valid", 64'(out_valid4), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      tick4();
      chk("bp_product_stable", 64'(p4), 64'h2A);
      chk("bp_out_valid_held", 64'(out_valid4), 64'd1);
      chk("bp_in_ready_low", 64'(in_ready4), 64'd0);
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    tick4();
    chk("bp_release_out_valid", 64'(out_valid4), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready4), 64'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick4();
      if (out_valid4) seen++;
    end
    chk("bp_single_transfer", 64'(seen), 64'd0);

    // Reset during the second iteration discards the operation
    a4 = 4'd9; b4 = 4'd11; s4 = 1'b0; in_valid4 = 1'b1;
    tick4();
    in_valid4 = 1'b0;
    tick4();
    rst4 = 1'b1;
    tick4();
    rst4 = 1'b0;
    chk("midrst_in_ready", 64'(in_ready4), 64'd1);
    chk("midrst_out_valid", 64'(out_valid4), 64'd0);
    chk("midrst_product", 64'(p4), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick4();
      if (out_valid4) seen++;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    run4(4'd3, 4'd5, 1'b0, 8'h0F, "after_rst");

    // Reset and in_valid together: nothing accepted
    a4 = 4'd5; b4 = 4'd5; in_valid4 = 1'b1; rst4 = 1'b1;
    tick4();
    rst4 = 1'b0; in_valid4 = 1'b0;
    chk("rst_wins_in_ready", 64'(in_ready4), 64'd1);
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      tick4();
      if (out_valid4) seen++;
    end
    chk("rst_wins_no_result", 64'(seen), 64'd0);

    // Randomised WIDTH=8 sweep with random backpressure
    fork
      begin : driver
        bit ok;
        bit rdy;
        for (int n = 0; n < 1000; n++) begin
          a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
          in_valid8 = 1'b1;
          ok = 1'b0;
          for (int w = 0; w < 200 && !ok; w++) begin
            rdy = in_ready8;
            tick4();
            if (rdy) ok = 1'b1;
          end
          if (!ok) begin
            chk("sweep_accept_timeout", 64'd0, 64'd1);
            break;
          end
          exp_q.push_back(ref_mul(a8, b8, s8));
          a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            in_valid8 = 1'b0;
            tick4();
          end
        end
        in_valid8 = 1'b0;
        drv_done = 1'b1;
      end
      begin : monitor
        int          cyc;
        bit          hold_prev;
        logic [15:0] last_p;
        logic [15:0] e;
        cyc = 0; hold_prev = 1'b0; last_p = 16'd0;
        while (got8 < 1000 && cyc < 60000) begin
          tick4();
          cyc++;
          if (hold_prev) chk("sweep_hold_stable", 64'(p8), 64'(last_p));
          out_ready8 = ($urandom_range(0, 3) != 0);
          if (out_valid8 && out_ready8) begin
            if (exp_q.size() == 0) begin
              chk("sweep_unexpected_result", 64'(p8), 64'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk("sweep_product", 64'(p8), 64'(e));
            end
            got8++;
            hold_prev = 1'b0;
          end else begin
            hold_prev = out_valid8;
            last_p = p8;
          end
        end
        if (cyc >= 60000) chk("sweep_timeout", 64'd0, 64'd1);
      end
    join

    out_ready8 = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick4();
      if (out_valid8) seen++;
    end
    chk("sweep_no_extra_result", 64'(seen), 64'd0);
    chk("sweep_driver_done", 64'(drv_done), 64'd1);
    chk("sweep_count", 64'(got8), 64'd1000);
    chk("sweep_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised, iterative shift-add multiplier. Next generation of the team's 4-bit combinational array multiplier.
- Trades area for latency: one partial-product row per clock, reusing a single gated adder row.
- Adds a per-operation signed/unsigned mode and valid/ready handshakes on both input and output.
- Sits between an operand source and a result consumer in datapaths where a WIDTH-cycle multiply is acceptable.

Parameters:
- WIDTH, 4, operand width in bits (>=2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a_in  input  WIDTH  multiplicand.
- b_in  input  WIDTH  multiplier.
- signed_in  input  1  1 = two's-complement operands; 0 = unsigned.
- out_valid  output  1  product available.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result; held stable while out_valid=1.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: in_ready=1, out_valid=0, product=0, state=IDLE, counter=0, internal registers=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a_in, b_in and signed_in. Clear the accumulator. Load counter=0. Go to BUSY.
  - BUSY: in_ready=0. Each cycle processes multiplier bit i=counter (LSB first).
    - If b[i]=1, add multiplicand<<i into the 2*WIDTH accumulator. In signed mode the multiplicand is sign-extended to 2*WIDTH.
    - Signed mode, i=WIDTH-1: subtract instead of add (two's-complement weight of the MSB).
    - Unsigned mode: always add, zero-extended.
    - Accumulator arithmetic is modulo 2^(2*WIDTH); no overflow flag, since the product always fits.
    - counter increments; after the i=WIDTH-1 step, go to DONE.
  - DONE: out_valid=1, product=accumulator. Stay in DONE until out_ready=1, then go to IDLE with out_valid=0.
- Latency:
  - Acceptance on edge k gives out_valid=1 after edge k+WIDTH.
  - With out_ready held high, the next accept is possible at edge k+WIDTH+2.
  - Throughput is one product per WIDTH+2 cycles.
- Backpressure: out_ready=0 in DONE holds product and out_valid indefinitely. in_ready stays 0.
- in_valid while not in IDLE is ignored; operands are not captured.
- Operand inputs, signed_in and in_valid may change freely after acceptance without affecting the result.
- Reset mid-operation (BUSY or DONE) aborts immediately to reset values. The partial result is discarded and no out_valid is produced.
- Simultaneous rst and in_valid: rst wins; nothing accepted.
- Zero operands take the full WIDTH iterations; there is no early termination.

Decomposition:
- Package seq_mult_pkg:
  - State enum {IDLE, BUSY, DONE}, encoded 2'b00/01/10.
  - Function for the signed/unsigned extension of the multiplicand to 2*WIDTH.
- Sub-module mult_pp_row (combinational):
  - Inputs: extended multiplicand, shift amount, gating bit, subtract flag, accumulator.
  - Output: next accumulator.
  - The parametrised analogue of the team's existing gated partial-product adder row; the top level holds the FSM, counter and registers.

Test Plan:
- WIDTH=4, unsigned: a=15, b=15, out_ready=1 -> out_valid rises exactly 4 cycles after the accept edge, product=8'hE1 (225). Then in_ready=1 one cycle after the handshake.
- WIDTH=4, signed: a=4'b1000 (-8), b=4'b1000 -> product=8'h40. Then a=-8, b=7 -> 8'hC8 (-56). Then a=7, b=-1 -> 8'hF9 (-7).
- Mode independence, WIDTH=4: a=4'hF, b=4'h2 unsigned -> 8'h1E; the same bits signed -> 8'hFE.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> product stable, in_valid pulses ignored, in_ready=0. Release -> exactly one transfer.
- Reset mid-BUSY: assert rst on the 2nd iteration -> next cycle in_ready=1, out_valid=0, product=0. A following multiply 3*5 returns 8'h0F.
- Randomised sweep, WIDTH=8, 1000 ops, both modes, random out_ready -> every product matches a reference model. No lost or duplicated results; input changes after acceptance have no effect.
